// File: rtl/dsm_dac_multi.sv
// dsm_dac_multi: multi-channel 1-bit DAC with first-order delta-sigma and PWM modes.
// Codes are double-buffered (shadow -> working) so a PWM period never changes mid-way.
module dsm_dac_multi #(
  parameter int unsigned C_CH  = 2,
  parameter int unsigned C_W   = 5,
  parameter logic        C_INV = 1'b0
) (
  input  logic                CK_i,
  input  logic                XARST_i,
  input  logic                CK_EE_i,
  input  logic                LD_i,
  input  logic [C_CH*C_W-1:0] DATss_i,
  input  logic [1:0]          MODE_i,
  output logic [C_CH-1:0]     DACs_o,
  output logic                WRAP_o
);

  localparam logic [C_W-1:0] PCTR_MAX = {C_W{1'b1}};
  localparam logic [C_W-1:0] PCTR_ONE = C_W'(1);

  typedef enum logic [1:0] {
    MODE_DSM  = 2'd0,
    MODE_PWM  = 2'd1,
    MODE_MUTE = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  logic [C_CH-1:0][C_W-1:0] shd_q, shd_d;
  logic [C_CH-1:0][C_W-1:0] wrk_q, wrk_d;
  // Only the low C_W accumulator bits are kept; the carry bit of ACC is
  // exactly what lands in dac_q, so it is not stored twice.
  logic [C_CH-1:0][C_W-1:0] acc_q, acc_d;
  logic [C_CH-1:0][C_W:0]   sum;
  logic [C_W-1:0]           pctr_q, pctr_d;
  mode_e                    mode_q, mode_d;
  logic [C_CH-1:0]          dac_q, dac_d;
  logic                     wrap_q, wrap_d;
  logic                     mode_chg;
  logic                     pctr_end;

  assign mode_chg = (MODE_i != mode_q);
  assign pctr_end = (pctr_q == PCTR_MAX);

  // Per-channel accumulator adds; only consumed in DSM mode.
  always_comb begin
    sum = '0;
    for (int k = 0; k < C_CH; k++) begin
      sum[k] = {1'b0, acc_q[k]} + {1'b0, wrk_q[k]};
    end
  end

  // Next-state logic for shadow/working codes, modulators and outputs.
  always_comb begin
    shd_d  = shd_q;
    wrk_d  = wrk_q;
    acc_d  = acc_q;
    pctr_d = pctr_q;
    mode_d = mode_q;
    dac_d  = dac_q;
    // WRAP is a single-cycle pulse, so it drops on every edge unless re-armed.
    wrap_d = 1'b0;

    if (LD_i) begin
      for (int k = 0; k < C_CH; k++) begin
        shd_d[k] = DATss_i[k*C_W +: C_W];
      end
    end

    if (CK_EE_i) begin
      mode_d = mode_e'(MODE_i);
      if (mode_chg) begin
        // Restart every modulator cleanly from the latest shadow codes.
        acc_d  = '0;
        pctr_d = '0;
        wrk_d  = shd_q;
        dac_d  = '0;
      end else begin
        case (mode_q)
          MODE_DSM: begin
            wrk_d = shd_q;
            for (int k = 0; k < C_CH; k++) begin
              acc_d[k] = sum[k][C_W-1:0];
              dac_d[k] = sum[k][C_W];
            end
          end
          MODE_PWM: begin
            for (int k = 0; k < C_CH; k++) begin
              dac_d[k] = (pctr_q < wrk_q[k]);
            end
            pctr_d = pctr_q + PCTR_ONE;
            // New codes only take effect at the period boundary.
            if (pctr_end) begin
              wrk_d  = shd_q;
              wrap_d = 1'b1;
            end
          end
          default: begin
            acc_d  = '0;
            pctr_d = '0;
            wrk_d  = shd_q;
            dac_d  = '0;
          end
        endcase
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      shd_q  <= '0;
      wrk_q  <= '0;
      acc_q  <= '0;
      pctr_q <= '0;
      mode_q <= MODE_DSM;
      dac_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      shd_q  <= shd_d;
      wrk_q  <= wrk_d;
      acc_q  <= acc_d;
      pctr_q <= pctr_d;
      mode_q <= mode_d;
      dac_q  <= dac_d;
      wrap_q <= wrap_d;
    end
  end

  // Polarity inversion sits after the register so reset yields {C_CH{C_INV}}.
  assign DACs_o = dac_q ^ {C_CH{C_INV}};
  assign WRAP_o = wrap_q;

endmodule
